write_response_sl: RTL and testbench

WRITE_RESPONSE_SL -- requirements
Module: write_response_sl

---
 rtl/write_response_sl_if.sv | 37 +++
 rtl/write_response_sl.sv | 96 +++++++++
 tb/tb_write_response_sl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_response_sl_if.sv
// write_response_sl_if
// Groups the write-completion input and the B (write response) channel of
// the write_response_sl block into one bundle.
//   i_wr_done  : upstream write path finished one write transaction
//   i_wr_resp  : response code for that completion (OKAY/EXOKAY/SLVERR/DECERR)
//   o_wr_ready : the response block can take a completion this cycle
//   BREADY     : bus master accepts the presented response
//   BVALID     : a write response is presented
//   BRESP      : the presented response code
// The slave modport is used by write_response_sl itself; the master modport
// is the view of whatever drives completions and consumes responses.
interface write_response_sl_if;
  logic       i_wr_done;
  logic [1:0] i_wr_resp;
  logic       o_wr_ready;
  logic       BREADY;
  logic       BVALID;
  logic [1:0] BRESP;

  modport slave (
    input  i_wr_done,
    input  i_wr_resp,
    input  BREADY,
    output o_wr_ready,
    output BVALID,
    output BRESP
  );

  modport master (
    output i_wr_done,
    output i_wr_resp,
    output BREADY,
    input  o_wr_ready,
    input  BVALID,
    input  BRESP
  );
endinterface

// File: rtl/write_response_sl.sv
// write_response_sl
// Queues write-completion response codes from the slave write path and
// presents them in order on the B channel. Also counts error responses
// (SLVERR/DECERR) as they are delivered to the master.
// Parameters:
//   DEPTH : pending-response queue depth (power of two, >= 2)
//   ERR_W : width of the saturating error counter
// Ports:
//   ACLK      : clock, all state changes on its rising edge
//   ARESET    : synchronous active-high reset
//   bus       : completion input and B channel (slave modport)
//   o_pending : number of queued responses not yet handshaken
//   o_err_cnt : number of SLVERR/DECERR responses delivered (saturating)
module write_response_sl #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  write_response_sl_if.slave       bus,
  output logic [$clog2(DEPTH):0]   o_pending,
  output logic [ERR_W-1:0]         o_err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [1:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Readiness depends only on the registered occupancy, so a pop in the
  // same cycle never frees a slot early; a full queue makes the upstream
  // path wait one extra cycle instead of creating a BREADY->ready path.
  assign w_full         = (r_count == FULL_CNT);
  assign w_valid        = (r_count != '0);
  assign bus.o_wr_ready = !w_full && !ARESET;
  assign w_push         = bus.i_wr_done && bus.o_wr_ready;
  assign w_pop          = w_valid && bus.BREADY;

  // The head entry is only shown while something is queued, otherwise the
  // bus sees OKAY so stale storage never leaks out.
  assign bus.BVALID = w_valid;
  assign bus.BRESP  = w_valid ? r_mem[r_rptr] : 2'b00;

  assign o_pending = r_count;
  assign o_err_cnt = r_err_cnt;

  // Response storage needs no reset: entries are only visible through the
  // occupancy count, which is cleared by reset.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.i_wr_resp;
    end
  end

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Error counter: bump on every delivered response whose upper code bit is
  // set (SLVERR or DECERR), sticking at all-ones rather than wrapping.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_err_cnt <= '0;
    end else if (w_pop && bus.BRESP[1] && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_write_response_sl.sv
// tb_write_response_sl
// Directed scenarios for write_response_sl with DEPTH=2 and ERR_W=2 so the
// error counter saturates quickly. Stimulus pushes expected response codes
// into a scoreboard queue when it offers a completion it expects to be
// accepted; an independent monitor pops and compares on every B handshake
// and keeps a saturating model of the error count.
module tb_write_response_sl;

  localparam int DEPTH   = 2;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic                   ACLK;
  logic                   ARESET;
  logic [$clog2(DEPTH):0] o_pending;
  logic [ERR_W-1:0]       o_err_cnt;

  write_response_sl_if bus ();

  write_response_sl #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .bus       (bus.slave),
    .o_pending (o_pending),
    .o_err_cnt (o_err_cnt)
  );

  int         total = 0;
  int         bad   = 0;
  logic [1:0] expQ [$];
  int         modelErr = 0;

  // Free-running clock, 10 time units per period.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    @(negedge ACLK);
  endtask

  task automatic applyStimulus(input logic done, input logic [1:0] resp,
                               input logic ready, input logic expAccept);
    bus.i_wr_done = done;
    bus.i_wr_resp = resp;
    bus.BREADY    = ready;
    if (done && expAccept) begin
      expQ.push_back(resp);
    end
  endtask

  task automatic doReset();
    step();
    ARESET = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    settle();
    checkOutput("rst_ready_low", bus.o_wr_ready, 0);
    step();
    ARESET = 1'b0;
    settle();
    checkOutput("rst_ready_high", bus.o_wr_ready, 1);
    checkOutput("rst_bvalid", bus.BVALID, 0);
    checkOutput("rst_pending", o_pending, 0);
    checkOutput("rst_err", o_err_cnt, 0);
  endtask

  // Monitor: on each negedge, compare the error counter against the model
  // and, when a handshake is about to happen, pop and compare the head.
  always @(negedge ACLK) begin
    logic [1:0] e;
    if (ARESET) begin
      expQ.delete();
      modelErr = 0;
    end else begin
      checkOutput("err_cnt", o_err_cnt, modelErr);
      if (bus.BVALID && bus.BREADY) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: actual=%0h required=none at %0t",
                   bus.BRESP, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("bresp", bus.BRESP, e);
          if (e[1] && modelErr != ERR_MAX) modelErr++;
        end
      end
    end
  end

  initial begin
    logic [1:0] streamResp [4];
    streamResp[0] = 2'b01;
    streamResp[1] = 2'b00;
    streamResp[2] = 2'b10;
    streamResp[3] = 2'b11;

    ARESET = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Power-on reset and release.
    step();
    settle();
    checkOutput("por_ready_low", bus.o_wr_ready, 0);
    step();
    settle();
    checkOutput("por_bvalid", bus.BVALID, 0);
    checkOutput("por_bresp", bus.BRESP, 0);
    checkOutput("por_pending", o_pending, 0);
    checkOutput("por_err", o_err_cnt, 0);
    step();
    ARESET = 1'b0;
    settle();
    checkOutput("por_ready_first", bus.o_wr_ready, 1);

    // Single SLVERR response held by BREADY=0 for three cycles.
    $display("[TB] single response");
    step(); applyStimulus(1'b1, 2'b10, 1'b0, 1'b1); settle();
    checkOutput("s1_ready", bus.o_wr_ready, 1);
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s1_bvalid", bus.BVALID, 1);
    checkOutput("s1_bresp", bus.BRESP, 2'b10);
    checkOutput("s1_pending", o_pending, 1);
    for (int i = 0; i < 2; i++) begin
      step(); settle();
      checkOutput("s1_hold_bvalid", bus.BVALID, 1);
      checkOutput("s1_hold_bresp", bus.BRESP, 2'b10);
    end
    step(); applyStimulus(1'b0, 2'b00, 1'b1, 1'b0); settle();
    checkOutput("s1_hs_bvalid", bus.BVALID, 1);
    checkOutput("s1_hs_bresp", bus.BRESP, 2'b10);
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s1_done_bvalid", bus.BVALID, 0);
    checkOutput("s1_done_pending", o_pending, 0);
    checkOutput("s1_done_err", o_err_cnt, 1);

    // Fill and back-pressure.
    $display("[TB] fill and back-pressure");
    doReset();
    step(); applyStimulus(1'b1, 2'b00, 1'b0, 1'b1); settle();
    checkOutput("s2_ready0", bus.o_wr_ready, 1);
    step(); applyStimulus(1'b1, 2'b11, 1'b0, 1'b1); settle();
    checkOutput("s2_ready1", bus.o_wr_ready, 1);
    checkOutput("s2_pending1", o_pending, 1);
    step(); applyStimulus(1'b1, 2'b01, 1'b0, 1'b0); settle();
    checkOutput("s2_full_pending", o_pending, 2);
    checkOutput("s2_full_ready", bus.o_wr_ready, 0);
    checkOutput("s2_full_bresp", bus.BRESP, 2'b00);
    step(); applyStimulus(1'b0, 2'b00, 1'b1, 1'b0); settle();
    checkOutput("s2_ignored_pending", o_pending, 2);
    checkOutput("s2_head0", bus.BRESP, 2'b00);
    step(); settle();
    checkOutput("s2_head1", bus.BRESP, 2'b11);
    checkOutput("s2_pending_drain", o_pending, 1);
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s2_empty", o_pending, 0);
    checkOutput("s2_bvalid", bus.BVALID, 0);
    checkOutput("s2_err", o_err_cnt, 1);

    // Streaming with BREADY held high.
    $display("[TB] streaming");
    doReset();
    for (int i = 0; i < 4; i++) begin
      step(); applyStimulus(1'b1, streamResp[i], 1'b1, 1'b1); settle();
      checkOutput("s3_ready", bus.o_wr_ready, 1);
      if (i > 0) begin
        checkOutput("s3_bresp", bus.BRESP, streamResp[i-1]);
        checkOutput("s3_pending", o_pending, 1);
      end
    end
    step(); applyStimulus(1'b0, 2'b00, 1'b1, 1'b0); settle();
    checkOutput("s3_last_bresp", bus.BRESP, 2'b11);
    checkOutput("s3_last_pending", o_pending, 1);
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s3_empty", o_pending, 0);
    checkOutput("s3_err", o_err_cnt, 2);

    // Full queue with a simultaneous pop: the push must wait a cycle.
    $display("[TB] full with simultaneous pop");
    doReset();
    step(); applyStimulus(1'b1, 2'b00, 1'b0, 1'b1); settle();
    step(); applyStimulus(1'b1, 2'b01, 1'b0, 1'b1); settle();
    checkOutput("s4_pending1", o_pending, 1);
    step(); applyStimulus(1'b1, 2'b10, 1'b1, 1'b0); settle();
    checkOutput("s4_full_pending", o_pending, 2);
    checkOutput("s4_full_ready", bus.o_wr_ready, 0);
    step(); applyStimulus(1'b1, 2'b10, 1'b0, 1'b1); settle();
    checkOutput("s4_after_pop_pending", o_pending, 1);
    checkOutput("s4_after_pop_ready", bus.o_wr_ready, 1);
    checkOutput("s4_after_pop_bresp", bus.BRESP, 2'b01);
    step(); applyStimulus(1'b0, 2'b00, 0, 1'b0); settle();
    checkOutput("s4_refill_pending", o_pending, 2);
    step(); applyStimulus(1'b0, 2'b00, 1'b1, 1'b0); settle();
    checkOutput("s4_head0", bus.BRESP, 2'b01);
    step(); settle();
    checkOutput("s4_head1", bus.BRESP, 2'b10);
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s4_empty", o_pending, 0);
    checkOutput("s4_err", o_err_cnt, 1);

    // Reset in the middle of operation discards queued responses.
    $display("[TB] reset mid-operation");
    doReset();
    step(); applyStimulus(1'b1, 2'b11, 1'b0, 1'b1); settle();
    step(); applyStimulus(1'b0, 2'b00, 1'b1, 1'b0); settle();
    checkOutput("s5_pre_bresp", bus.BRESP, 2'b11);
    step(); applyStimulus(1'b1, 2'b10, 1'b0, 1'b1); settle();
    checkOutput("s5_pre_err", o_err_cnt, 1);
    step(); applyStimulus(1'b1, 2'b11, 1'b0, 1'b1); settle();
    checkOutput("s5_pending1", o_pending, 1);
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s5_pending2", o_pending, 2);
    checkOutput("s5_bvalid", bus.BVALID, 1);
    step(); ARESET = 1'b1; settle();
    step(); ARESET = 1'b0; settle();
    checkOutput("s5_rst_bvalid", bus.BVALID, 0);
    checkOutput("s5_rst_pending", o_pending, 0);
    checkOutput("s5_rst_err", o_err_cnt, 0);
    checkOutput("s5_rst_ready", bus.o_wr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      checkOutput("s5_no_stale_bvalid", bus.BVALID, 0);
    end

    // Error counter saturation with five DECERR handshakes.
    $display("[TB] error counter saturation");
    doReset();
    for (int i = 0; i < 5; i++) begin
      step(); applyStimulus(1'b1, 2'b11, 1'b1, 1'b1); settle();
      checkOutput("s6_ready", bus.o_wr_ready, 1);
    end
    step(); applyStimulus(1'b0, 2'b00, 1'b1, 1'b0); settle();
    step(); applyStimulus(1'b0, 2'b00, 1'b0, 1'b0); settle();
    checkOutput("s6_err_sat", o_err_cnt, 3);
    checkOutput("s6_pending", o_pending, 0);
    for (int i = 0; i < 2; i++) begin
      step(); settle();
      checkOutput("s6_err_hold", o_err_cnt, 3);
    end

    checkOutput("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
